// File: rtl/alaw_pcm_tx.sv
// Serial PCM transmitter: buffers A-law codes in a small FIFO and shifts them out MSB-first
// as back-to-back 8-bit frames with frame sync, filling underruns with IDLE_CODE.
module alaw_pcm_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          BIT_DIV    = 8,
  parameter logic [7:0]  IDLE_CODE  = 8'hD5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_alaw,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          pcm_data,
  output logic                          pcm_fsync,
  output logic                          pcm_bit_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(BIT_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(BIT_DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          started;

  logic       tick;
  logic       load;
  logic       push;
  logic       pop;
  logic [7:0] load_byte;

  // Pop decisions use the pre-edge level, so a byte pushed on a load edge waits a frame.
  always_comb begin
    tick      = (div_cnt == DIV_LAST);
    load      = !started || (bit_idx == 3'd0);
    in_ready  = (fifo_level != LEVEL_FULL);
    push      = in_valid && in_ready;
    pop       = tick && load && (fifo_level != '0);
    load_byte = pop ? mem[rd_ptr] : IDLE_CODE;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_alaw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt       <= '0;
      bit_idx       <= 3'd7;
      started       <= 1'b0;
      shift         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      pcm_data      <= 1'b0;
      pcm_fsync     <= 1'b0;
      pcm_bit_start <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      div_cnt       <= tick ? '0 : div_cnt + 1'b1;
      pcm_bit_start <= tick;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_level <= fifo_level + LW'(push) - LW'(pop);

      // Frame boundary loads a new byte; otherwise walk down the current one.
      if (tick) begin
        if (load) begin
          shift     <= load_byte;
          pcm_data  <= load_byte[7];
          pcm_fsync <= 1'b1;
          bit_idx   <= 3'd7;
          started   <= 1'b1;
          if (!pop && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 1'b1;
          end
        end else begin
          bit_idx   <= bit_idx - 3'd1;
          pcm_data  <= shift[bit_idx - 3'd1];
          pcm_fsync <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alaw_pcm_tx.sv
// Self-checking bench for alaw_pcm_tx: a frame monitor compares every serial frame
// against a scoreboard of accepted bytes, falling back to the idle code when none is due.
module tb_alaw_pcm_tx;

  localparam int         DEPTH = 4;
  localparam int         BDIV  = 4;
  localparam int         LW    = 3;
  localparam logic [7:0] IDLE  = 8'hD5;

  logic          clk;
  logic          rst;
  logic [7:0]    in_alaw;
  logic          in_valid;
  logic          in_ready;
  logic          pcm_data;
  logic          pcm_fsync;
  logic          pcm_bit_start;
  logic [LW-1:0] fifo_level;
  logic [7:0]    underrun_cnt;

  alaw_pcm_tx #(
    .FIFO_DEPTH (DEPTH),
    .BIT_DIV    (BDIV),
    .IDLE_CODE  (IDLE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_alaw       (in_alaw),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .pcm_data      (pcm_data),
    .pcm_fsync     (pcm_fsync),
    .pcm_bit_start (pcm_bit_start),
    .fifo_level    (fifo_level),
    .underrun_cnt  (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         stamp;
  } entry_t;

  entry_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int frames_done = 0;

  bit         in_frame = 0;
  int         bitcnt = 0;
  logic [7:0] frame_exp = '0;
  logic       hold_val = 1'b0;
  int         last_start = 0;

  // A byte is due in a frame only if it was accepted on an edge before that frame's load edge.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      bitcnt = 0;
    end else if (pcm_bit_start) begin
      if (in_frame) begin
        checks++;
        if (cyc - last_start != BDIV) begin
          fails++;
          $display("[TB] FAIL bit_period: got %0d cycles, expected %0d", cyc - last_start, BDIV);
        end
      end
      last_start = cyc;
      if (pcm_fsync) begin
        if (in_frame) begin
          checks++;
          if (bitcnt != 8) begin
            fails++;
            $display("[TB] FAIL frame_len: got %0d bits, expected 8", bitcnt);
          end
        end
        in_frame = 1;
        bitcnt = 0;
        if (exp_q.size() > 0 && exp_q[0].stamp < cyc) frame_exp = exp_q.pop_front().data;
        else frame_exp = IDLE;
      end else if (in_frame && bitcnt == 8) begin
        checks++;
        fails++;
        $display("[TB] FAIL frame_sync: got fsync 0 at frame boundary, expected 1");
        in_frame = 0;
      end
      if (in_frame) begin
        checks++;
        if (pcm_data !== frame_exp[7-bitcnt]) begin
          fails++;
          $display("[TB] FAIL frame_bit: byte %02h bit %0d got %b expected %b",
                   frame_exp, 7 - bitcnt, pcm_data, frame_exp[7-bitcnt]);
        end
        hold_val = pcm_data;
        bitcnt++;
        if (bitcnt == 8) frames_done++;
      end
    end else if (in_frame) begin
      checks++;
      if (pcm_data !== hold_val) begin
        fails++;
        $display("[TB] FAIL bit_hold: got %b expected %b", pcm_data, hold_val);
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input int budget);
    bit full;
    bit accepted = 0;
    int stamp;
    in_alaw = d;
    in_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      full = (exp_q.size() >= DEPTH);
      checks++;
      if (in_ready !== !full) begin
        fails++;
        $display("[TB] FAIL in_ready: got %b expected %b", in_ready, !full);
      end
      checks++;
      if (fifo_level !== LW'(exp_q.size())) begin
        fails++;
        $display("[TB] FAIL fifo_level: got %0d expected %0d", fifo_level, exp_q.size());
      end
      stamp = cyc + 1;
      @(posedge clk);
      #1;
      if (!full) begin
        exp_q.push_back('{d, stamp});
        accepted = 1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!accepted) begin
      fails++;
      $display("[TB] FAIL push_timeout: byte %02h got not accepted, expected accepted", d);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target = frames_done + n;
    for (int i = 0; i < budget; i++) begin
      if (frames_done >= target) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (frames_done < target) begin
      fails++;
      $display("[TB] FAIL frame_timeout: got %0d frames expected %0d", frames_done, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_alaw = 8'hAA;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pcm_data !== 1'b0) begin fails++; $display("[TB] FAIL rst_data: got %b expected 0", pcm_data); end
    checks++;
    if (pcm_fsync !== 1'b0) begin fails++; $display("[TB] FAIL rst_fsync: got %b expected 0", pcm_fsync); end
    checks++;
    if (pcm_bit_start !== 1'b0) begin fails++; $display("[TB] FAIL rst_bit_start: got %b expected 0", pcm_bit_start); end
    checks++;
    if (underrun_cnt !== 8'd0) begin fails++; $display("[TB] FAIL rst_underrun: got %0d expected 0", underrun_cnt); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fifo_level !== '0) begin fails++; $display("[TB] FAIL rst_level: got %0d expected 0", fifo_level); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_byte();
    do_reset(2);
    push_byte(8'hA5, 4);
    repeat (3) @(negedge clk);
    checks++;
    if (pcm_fsync !== 1'b0) begin fails++; $display("[TB] FAIL early_fsync: got %b expected 0", pcm_fsync); end
    @(negedge clk);
    checks++;
    if (pcm_fsync !== 1'b1) begin fails++; $display("[TB] FAIL first_fsync: got %b expected 1", pcm_fsync); end
    checks++;
    if (pcm_bit_start !== 1'b1) begin fails++; $display("[TB] FAIL first_bit_start: got %b expected 1", pcm_bit_start); end
    checks++;
    if (pcm_data !== 1'b1) begin fails++; $display("[TB] FAIL first_bit: got %b expected 1", pcm_data); end
    @(posedge clk);
    #1;
    wait_frames(1, 64);
    checks++;
    if (underrun_cnt !== 8'd0) begin fails++; $display("[TB] FAIL single_underrun: got %0d expected 0", underrun_cnt); end
  endtask

  task automatic test_idle_frames();
    wait_frames(3, 3 * 8 * BDIV + 40);
    checks++;
    if (underrun_cnt !== 8'd3) begin fails++; $display("[TB] FAIL idle_underrun: got %0d expected 3", underrun_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) push_byte(8'(i), 4);
    checks++;
    if (fifo_level !== LW'(4)) begin fails++; $display("[TB] FAIL full_level: got %0d expected 4", fifo_level); end
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready); end
    push_byte(8'h05, 80);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size()); end
    wait_frames(1, 64);
  endtask

  task automatic test_reset_mid_frame();
    do_reset(2);
    push_byte(8'h3C, 4);
    push_byte(8'hC3, 4);
    push_byte(8'h5A, 4);
    repeat (18) @(posedge clk);
    #1;
    checks++;
    if (fifo_level !== LW'(2)) begin fails++; $display("[TB] FAIL mid_level: got %0d expected 2", fifo_level); end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pcm_data !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_data: got %b expected 0", pcm_data); end
    checks++;
    if (pcm_fsync !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_fsync: got %b expected 0", pcm_fsync); end
    checks++;
    if (fifo_level !== '0) begin fails++; $display("[TB] FAIL mid_rst_level: got %0d expected 0", fifo_level); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (pcm_fsync !== 1'b0) begin fails++; $display("[TB] FAIL restart_early: got %b expected 0", pcm_fsync); end
    @(negedge clk);
    checks++;
    if (pcm_fsync !== 1'b1 || pcm_data !== IDLE[7]) begin
      fails++;
      $display("[TB] FAIL restart_frame: got fsync %b data %b expected 1 %b", pcm_fsync, pcm_data, IDLE[7]);
    end
    @(posedge clk);
    #1;
    wait_frames(1, 64);
    checks++;
    if (underrun_cnt !== 8'd1) begin fails++; $display("[TB] FAIL restart_underrun: got %0d expected 1", underrun_cnt); end
  endtask

  task automatic test_underrun_saturate();
    do_reset(2);
    wait_frames(254, 254 * 8 * BDIV + 50);
    checks++;
    if (underrun_cnt !== 8'd254) begin fails++; $display("[TB] FAIL sat_254: got %0d expected 254", underrun_cnt); end
    wait_frames(2, 2 * 8 * BDIV + 50);
    checks++;
    if (underrun_cnt !== 8'd255) begin fails++; $display("[TB] FAIL sat_256: got %0d expected 255", underrun_cnt); end
    wait_frames(44, 44 * 8 * BDIV + 50);
    checks++;
    if (underrun_cnt !== 8'd255) begin fails++; $display("[TB] FAIL sat_300: got %0d expected 255", underrun_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_alaw = '0;
    test_reset();
    test_single_byte();
    test_idle_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_underrun_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
